// File: rtl/fetch_realign_queue_pkg.sv
// Shared types and helpers for the fetch realignment queue.
package fetch_realign_queue_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        compressed;
    logic        ex;
  } fetch_entry_t;

  // A parcel is the start of a compressed instruction unless its low bits are 2'b11.
  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_entry_fifo.sv
// Circular instruction buffer with two write ports (wr0 at wr_ptr, wr1 right after) and one read port.
module fetch_entry_fifo
  import fetch_realign_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       wr0_en,
  input  fetch_entry_t               wr0_data,
  input  logic                       wr1_en,
  input  fetch_entry_t               wr1_data,
  input  logic                       rd_en,
  output fetch_entry_t               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr, wr1_idx;
  logic [CW-1:0]  count_q, count_d;

  // wr1 lands in the slot after wr0 when both fire, so pointer wrap is free for power-of-two depth.
  assign wr1_idx = wr_ptr + PW'(wr0_en);
  assign count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr0_en) mem[wr_ptr]  <= wr0_data;
      if (wr1_en) mem[wr1_idx] <= wr1_data;
      wr_ptr  <= wr_ptr + PW'(wr0_en) + PW'(wr1_en);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_realign_queue.sv
// Splits aligned fetch words into parcels, rebuilds straddling 32-bit instructions and queues them for decode.
module fetch_realign_queue
  import fetch_realign_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic [63:0] fetch_addr_i,
  input  logic        fetch_ex_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        is_compressed_o,
  output logic        ex_o
);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CW-1:0] count_q;
  logic          hold_valid_q, hold_valid_d;
  logic [15:0]   hold_parcel_q, hold_parcel_d;
  logic [63:0]   hold_pc_q, hold_pc_d;
  fetch_entry_t  e0, e1, head, upper_e;
  logic          push0, push1, pop, accept, u_en, u_slot1;
  logic [63:0]   base;
  logic [15:0]   lo, hi;

  // Two free slots guarantee room for the worst-case double push.
  assign fetch_ready_o = !flush_i && (count_q <= CW'(DEPTH - 2));
  assign accept        = fetch_valid_i && fetch_ready_o;
  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i;

  assign base    = {fetch_addr_i[63:2], 2'b00};
  assign lo      = fetch_rdata_i[15:0];
  assign hi      = fetch_rdata_i[31:16];
  assign upper_e = '{instr: {16'h0, hi}, pc: base + 64'd2, compressed: 1'b1, ex: 1'b0};

  always_comb begin
    push0         = 1'b0;
    push1         = 1'b0;
    e0            = '0;
    e1            = '0;
    u_en          = 1'b0;
    u_slot1       = 1'b0;
    hold_valid_d  = hold_valid_q;
    hold_parcel_d = hold_parcel_q;
    hold_pc_d     = hold_pc_q;
    if (accept) begin
      if (fetch_ex_i) begin
        push0        = 1'b1;
        e0           = '{instr: fetch_rdata_i, pc: fetch_addr_i, compressed: 1'b0, ex: 1'b1};
        hold_valid_d = 1'b0;
      end else if (hold_valid_q) begin
        push0   = 1'b1;
        e0      = '{instr: {lo, hold_parcel_q}, pc: hold_pc_q, compressed: 1'b0, ex: 1'b0};
        u_en    = 1'b1;
        u_slot1 = 1'b1;
      end else if (!fetch_addr_i[1]) begin
        push0 = 1'b1;
        if (is_rvc(lo)) begin
          e0      = '{instr: {16'h0, lo}, pc: base, compressed: 1'b1, ex: 1'b0};
          u_en    = 1'b1;
          u_slot1 = 1'b1;
        end else begin
          e0           = '{instr: fetch_rdata_i, pc: base, compressed: 1'b0, ex: 1'b0};
          hold_valid_d = 1'b0;
        end
      end else begin
        u_en = 1'b1;
      end

      // Upper parcel: either a compressed instruction or the first half of a straddler.
      if (u_en) begin
        if (is_rvc(hi)) begin
          hold_valid_d = 1'b0;
          if (u_slot1) begin
            push1 = 1'b1;
            e1    = upper_e;
          end else begin
            push0 = 1'b1;
            e0    = upper_e;
          end
        end else begin
          hold_valid_d  = 1'b1;
          hold_parcel_d = hi;
          hold_pc_d     = base + 64'd2;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q  <= 1'b0;
      hold_parcel_q <= '0;
      hold_pc_q     <= '0;
    end else if (flush_i) begin
      hold_valid_q  <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_parcel_q <= hold_parcel_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  fetch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .wr0_en   (push0),
    .wr0_data (e0),
    .wr1_en   (push1),
    .wr1_data (e1),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (count_q)
  );

  assign instr_o         = head.instr;
  assign pc_o            = head.pc;
  assign is_compressed_o = head.compressed;
  assign ex_o            = head.ex;

endmodule

// File: tb/tb_fetch_realign_queue.sv
// Directed bench for fetch_realign_queue with an in-order scoreboard of expected decoder entries.
module tb_fetch_realign_queue;
  import fetch_realign_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, fetch_valid_i, fetch_ex_i, instr_ready_i;
  logic        fetch_ready_o, instr_valid_o, is_compressed_o, ex_o;
  logic [31:0] fetch_rdata_i, instr_o;
  logic [63:0] fetch_addr_i, pc_o;

  fetch_entry_t sb[$];
  int tests = 0;
  int fails = 0;

  fetch_realign_queue #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_rdata_i   (fetch_rdata_i),
    .fetch_addr_i    (fetch_addr_i),
    .fetch_ex_i      (fetch_ex_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .is_compressed_o (is_compressed_o),
    .ex_o            (ex_o)
  );

  always #5 clk_i = ~clk_i;

  // Every handshake with the decoder is compared against the scoreboard head.
  always @(negedge clk_i) begin
    fetch_entry_t got, want;
    if (instr_valid_o && instr_ready_i) begin
      got = '{instr: instr_o, pc: pc_o, compressed: is_compressed_o, ex: ex_o};
      tests++;
      if (sb.size() == 0) begin
        assert (got === '0) else begin
          fails++;
          $error("FAIL unexpected_entry got instr=%h pc=%h c=%b ex=%b exp none", got.instr, got.pc, got.compressed, got.ex);
        end
      end else begin
        want = sb.pop_front();
        assert (got === want) else begin
          fails++;
          $error("FAIL entry got instr=%h pc=%h c=%b ex=%b exp instr=%h pc=%h c=%b ex=%b",
                 got.instr, got.pc, got.compressed, got.ex, want.instr, want.pc, want.compressed, want.ex);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, got, want);
    end
  endtask

  task automatic exp_push(input logic [31:0] i, input logic [63:0] pc, input logic c, input logic x);
    sb.push_back('{instr: i, pc: pc, compressed: c, ex: x});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic fetch(input logic [31:0] d, input logic [63:0] a, input logic x);
    logic done;
    done          = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = d;
    fetch_addr_i  = a;
    fetch_ex_i    = x;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk_i);
      if (fetch_ready_o) done = 1'b1;
      @(posedge clk_i);
      #1;
    end
    fetch_valid_i = 1'b0;
    fetch_ex_i    = 1'b0;
    if (!done) check("fetch_accept", {63'd0, done}, 64'd1);
  endtask

  task automatic drain();
    instr_ready_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (!instr_valid_o && sb.size() == 0) break;
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_valid", {63'd0, instr_valid_o}, 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_ex_i = 1'b0;
    fetch_rdata_i = '0; fetch_addr_i = '0; instr_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    check("rst_valid", {63'd0, instr_valid_o}, 64'd0);
    check("rst_instr", {32'd0, instr_o}, 64'd0);
    check("rst_pc", pc_o, 64'd0);
    check("rst_comp_ex", {62'd0, is_compressed_o, ex_o}, 64'd0);
    check("rst_ready", {63'd0, fetch_ready_o}, 64'd1);
    @(posedge clk_i); #1;

    // Aligned 32-bit instruction, visible the cycle after accept.
    exp_push(32'h00B50533, 64'h80000000, 1'b0, 1'b0);
    fetch(32'h00B50533, 64'h80000000, 1'b0);
    @(negedge clk_i);
    check("rvi_latency", {63'd0, instr_valid_o}, 64'd1);
    @(posedge clk_i); #1;
    drain();

    // Two compressed instructions in one word.
    exp_push(32'h00000505, 64'h80000000, 1'b1, 1'b0);
    exp_push(32'h00000005, 64'h80000002, 1'b1, 1'b0);
    fetch(32'h00050505, 64'h80000000, 1'b0);
    drain();

    // Straddling instruction across two words.
    exp_push(32'h00000001, 64'h80000000, 1'b1, 1'b0);
    fetch(32'h05330001, 64'h80000000, 1'b0);
    exp_push(32'h00B50533, 64'h80000002, 1'b0, 1'b0);
    exp_push(32'h00000001, 64'h80000006, 1'b1, 1'b0);
    fetch(32'h000100B5, 64'h80000004, 1'b0);
    drain();

    // Entry at the upper parcel; lower parcel ignored.
    exp_push(32'h00000505, 64'h80000002, 1'b1, 1'b0);
    fetch(32'h0505FFFF, 64'h80000002, 1'b0);
    drain();

    // Backpressure: count 1 keeps ready, count 3 drops it.
    instr_ready_i = 1'b0;
    exp_push(32'h00B50533, 64'h80000010, 1'b0, 1'b0);
    fetch(32'h00B50533, 64'h80000010, 1'b0);
    @(negedge clk_i);
    check("bp_ready_cnt1", {63'd0, fetch_ready_o}, 64'd1);
    @(posedge clk_i); #1;
    exp_push(32'h00000505, 64'h80000014, 1'b1, 1'b0);
    exp_push(32'h00000005, 64'h80000016, 1'b1, 1'b0);
    fetch(32'h00050505, 64'h80000014, 1'b0);
    @(negedge clk_i);
    check("bp_ready_cnt3", {63'd0, fetch_ready_o}, 64'd0);
    check("bp_head_pc", pc_o, 64'h80000010);
    @(posedge clk_i); #1;
    drain();

    // Backpressure up to a full queue.
    instr_ready_i = 1'b0;
    exp_push(32'h00000505, 64'h80000020, 1'b1, 1'b0);
    exp_push(32'h00000005, 64'h80000022, 1'b1, 1'b0);
    fetch(32'h00050505, 64'h80000020, 1'b0);
    exp_push(32'h00000505, 64'h80000024, 1'b1, 1'b0);
    exp_push(32'h00000005, 64'h80000026, 1'b1, 1'b0);
    fetch(32'h00050505, 64'h80000024, 1'b0);
    @(negedge clk_i);
    check("bp_ready_full", {63'd0, fetch_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    drain();

    // Flush with three entries queued and the hold loaded.
    instr_ready_i = 1'b0;
    fetch(32'h00050505, 64'h80000000, 1'b0);
    fetch(32'h05330001, 64'h80000004, 1'b0);
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_ready", {63'd0, fetch_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_valid", {63'd0, instr_valid_o}, 64'd0);
    @(posedge clk_i); #1;
    instr_ready_i = 1'b1;
    exp_push(32'h00B50533, 64'h80000100, 1'b0, 1'b0);
    fetch(32'h00B50533, 64'h80000100, 1'b0);
    drain();

    // Exception word, then an exception that discards a loaded hold.
    exp_push(32'hDEADBEEF, 64'h80000202, 1'b0, 1'b1);
    fetch(32'hDEADBEEF, 64'h80000202, 1'b1);
    exp_push(32'h00000001, 64'h80000300, 1'b1, 1'b0);
    fetch(32'h05330001, 64'h80000300, 1'b0);
    exp_push(32'h12345677, 64'h80000304, 1'b0, 1'b1);
    fetch(32'h12345677, 64'h80000304, 1'b1);
    exp_push(32'h00B50533, 64'h80000400, 1'b0, 1'b0);
    fetch(32'h00B50533, 64'h80000400, 1'b0);
    drain();

    // Reset mid-operation zeroes the head entry.
    instr_ready_i = 1'b0;
    fetch(32'h00B50533, 64'h80000500, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_valid", {63'd0, instr_valid_o}, 64'd0);
    check("mid_rst_instr", {32'd0, instr_o}, 64'd0);
    check("mid_rst_pc", pc_o, 64'd0);
    check("mid_rst_ready", {63'd0, fetch_ready_o}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
